// File: rtl/spdif_bmc_decoder.sv
// S/PDIF biphase-mark receiver: finds preambles on the line's transition stream, checks the
// BMC coding, assembles 28-bit subframes (slots 4..31) and presents them on a valid/ready port.
module spdif_bmc_decoder (
  input  logic        clk128,
  input  logic        reset,
  input  logic        spdif,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [27:0] o_subframe,
  output logic [1:0]  o_preamble,
  output logic        parity_error,
  output logic        is_locked,
  output logic        code_violation,
  output logic        is_overrun
);
  typedef enum logic [1:0] {HUNT, DATA, PRE} state_t;

  localparam logic [1:0] TY_B = 2'b00;
  localparam logic [1:0] TY_M = 2'b01;
  localparam logic [1:0] TY_W = 2'b10;

  state_t      state, state_n;
  logic        s_q, s_prev, t;
  logic [7:0]  hist, win;
  logic [1:0]  phase;
  logic [3:0]  nib_cnt;
  logic [27:0] sf;
  logic        sf_done;
  logic [1:0]  cur_type, hit_type;
  logic        is_b, is_m, is_w, hit, nib_ok, pre_ok, nib_end;
  logic        viol, lock_set, load_type, shift_en, sf_end;

  // Only transitions carry information, so line polarity is irrelevant.
  assign t        = s_q ^ s_prev;
  assign win      = {hist[6:0], t};
  assign is_b     = (win == 8'h9C);
  assign is_m     = (win == 8'h93);
  assign is_w     = (win == 8'h96);
  assign hit      = is_b | is_m | is_w;
  assign hit_type = is_m ? TY_M : (is_w ? TY_W : TY_B);
  assign nib_end  = (phase == 2'd3);
  assign nib_ok   = win[3] & win[1];
  assign pre_ok   = (cur_type == TY_W) ? (is_b | is_m) : is_w;

  always_comb begin
    state_n   = state;
    viol      = 1'b0;
    lock_set  = 1'b0;
    load_type = 1'b0;
    shift_en  = 1'b0;
    sf_end    = 1'b0;
    case (state)
      HUNT: begin
        if (hit) begin
          state_n   = DATA;
          lock_set  = 1'b1;
          load_type = 1'b1;
        end
      end
      DATA: begin
        if (nib_end) begin
          if (!nib_ok) begin
            viol    = 1'b1;
            state_n = HUNT;
          end else begin
            shift_en = 1'b1;
            if (nib_cnt == 4'd13) begin
              sf_end  = 1'b1;
              state_n = PRE;
            end
          end
        end
      end
      PRE: begin
        if (nib_end && nib_cnt == 4'd1) begin
          if (pre_ok) begin
            state_n   = DATA;
            load_type = 1'b1;
          end else begin
            viol    = 1'b1;
            state_n = HUNT;
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge clk128) begin
    if (reset) state <= HUNT;
    else       state <= state_n;
  end

  always_ff @(posedge clk128) begin
    if (reset) begin
      s_q            <= 1'b0;
      s_prev         <= 1'b0;
      hist           <= '0;
      phase          <= '0;
      nib_cnt        <= '0;
      sf             <= '0;
      sf_done        <= 1'b0;
      cur_type       <= TY_B;
      is_locked      <= 1'b0;
      code_violation <= 1'b0;
    end else begin
      s_q    <= spdif;
      s_prev <= s_q;
      hist   <= win;
      // Counters restart on every state change so each field starts at phase 0.
      if (state == HUNT || state_n != state) begin
        phase   <= '0;
        nib_cnt <= '0;
      end else begin
        phase <= phase + 2'd1;
        if (nib_end) nib_cnt <= nib_cnt + 4'd1;
      end
      if (shift_en)  sf <= {win[0], win[2], sf[27:2]};
      sf_done <= sf_end;
      if (load_type) cur_type <= hit_type;
      if (lock_set)  is_locked <= 1'b1;
      else if (viol) is_locked <= 1'b0;
      code_violation <= viol;
    end
  end

  // sf and cur_type are untouched for at least 8 clocks after sf_end, so the output
  // stage can read them directly one clock later.
  always_ff @(posedge clk128) begin
    if (reset) begin
      o_valid      <= 1'b0;
      o_subframe   <= '0;
      o_preamble   <= '0;
      parity_error <= 1'b0;
      is_overrun   <= 1'b0;
    end else if (sf_done) begin
      o_valid      <= 1'b1;
      o_subframe   <= sf;
      o_preamble   <= cur_type;
      parity_error <= ^sf;
      is_overrun   <= o_valid & ~o_ready;
    end else begin
      if (o_ready) o_valid <= 1'b0;
      is_overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spdif_bmc_decoder.sv
// Bench for spdif_bmc_decoder: drives BMC transitions built from nibbles and checks
// delivered subframes against a queue of expected {preamble, parity, data} records.
module tb_spdif_bmc_decoder;
  logic        clk128 = 1'b0, reset = 1'b1, spdif = 1'b0, o_ready = 1'b0;
  logic        o_valid, parity_error, is_locked, code_violation, is_overrun;
  logic [27:0] o_subframe;
  logic [1:0]  o_preamble;

  logic        line = 1'b0;
  bit          rand_ready = 1'b0;
  int          n_cmp = 0, n_fail = 0;
  int          viol_cnt = 0, ovr_cnt = 0, valid_cycles = 0;
  logic [30:0] got_q[$];

  spdif_bmc_decoder dut (
    .clk128(clk128), .reset(reset), .spdif(spdif),
    .o_valid(o_valid), .o_ready(o_ready), .o_subframe(o_subframe),
    .o_preamble(o_preamble), .parity_error(parity_error), .is_locked(is_locked),
    .code_violation(code_violation), .is_overrun(is_overrun)
  );

  always #5 clk128 = ~clk128;

  always @(negedge clk128) begin
    if (o_valid && o_ready) got_q.push_back({o_preamble, parity_error, o_subframe});
    if (code_violation) viol_cnt++;
    if (is_overrun) ovr_cnt++;
    if (o_valid) valid_cycles++;
  end

  task automatic half(input logic tt);
    line  = line ^ tt;
    spdif = line;
    @(posedge clk128); #1;
    if (rand_ready) o_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic nib(input logic [3:0] n);
    for (int i = 3; i >= 0; i--) half(n[i]);
  endtask

  task automatic send_pre(input logic [1:0] ty);
    nib(4'h9);
    nib(ty == 2'b00 ? 4'hC : (ty == 2'b01 ? 4'h3 : 4'h6));
  endtask

  task automatic send_nibs(input logic [27:0] d, input int first, input int last);
    for (int k = first; k <= last; k++) nib({1'b1, d[2*k], 1'b1, d[2*k+1]});
  endtask

  task automatic send_data(input logic [27:0] d);
    send_nibs(d, 0, 13);
  endtask

  task automatic idle(input int n);
    repeat (n) half(1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rand_ready = 1'b0;
    o_ready = 1'b0;
    @(posedge clk128); #1;
    @(posedge clk128); #1;
    reset = 1'b0;
    got_q.delete();
  endtask

  function automatic logic [27:0] rnd28();
    return 28'($urandom);
  endfunction

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({o_valid, o_subframe, o_preamble, parity_error, is_locked, code_violation, is_overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b sf=%h pre=%b par=%b lock=%b cv=%b ov=%b required all 0",
               o_valid, o_subframe, o_preamble, parity_error, is_locked, code_violation, is_overrun);
    end
  endtask

  task automatic test_latency(input logic pol);
    do_reset();
    line = pol; spdif = pol;
    idle(4);
    send_pre(2'b00);
    send_data(28'h0);
    half(1'b0);
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early pol=%b: o_valid got %b required 0", pol, o_valid);
    end
    half(1'b0);
    n_cmp++;
    if ({o_valid, o_preamble, o_subframe, parity_error, is_locked} !== {1'b1, 2'b00, 28'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL latency_b_zero pol=%b: got v=%b pre=%b sf=%h par=%b lock=%b required 1 00 0000000 0 1",
               pol, o_valid, o_preamble, o_subframe, parity_error, is_locked);
    end
  endtask

  task automatic test_parity(input logic [27:0] d);
    int vc0;
    do_reset();
    o_ready = 1'b1;
    idle(3);
    vc0 = valid_cycles;
    send_pre(2'b01);
    send_data(d);
    idle(4);
    n_cmp++;
    if (got_q.size() != 1 || valid_cycles - vc0 != 1) begin
      n_fail++;
      $display("FAIL parity_count d=%h: transfers %0d valid_cycles %0d required 1 and 1",
               d, got_q.size(), valid_cycles - vc0);
    end else begin
      n_cmp++;
      if (got_q[0] !== {2'b01, ^d, d}) begin
        n_fail++;
        $display("FAIL parity_data: got %h required %h", got_q[0], {2'b01, ^d, d});
      end
    end
  endtask

  task automatic test_violation();
    logic [27:0] d, d2;
    int v0;
    do_reset();
    o_ready = 1'b1;
    d = rnd28();
    d2 = rnd28();
    idle(2);
    v0 = viol_cnt;
    send_pre(2'b00);
    send_nibs(d, 0, 4);
    nib(4'h8);
    half(1'b0);
    n_cmp++;
    if ({code_violation, is_locked} !== 2'b10) begin
      n_fail++;
      $display("FAIL bad_nibble: cv=%b lock=%b required cv=1 lock=0", code_violation, is_locked);
    end
    half(1'b0);
    n_cmp++;
    if (code_violation !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_nibble_pulse: cv got %b required 0", code_violation);
    end
    idle(4);
    send_pre(2'b10);
    send_data(d2);
    idle(4);
    n_cmp++;
    if (got_q.size() != 1 || viol_cnt - v0 != 1 || is_locked !== 1'b1) begin
      n_fail++;
      $display("FAIL relock_count: transfers %0d violations %0d lock %b required 1 1 1",
               got_q.size(), viol_cnt - v0, is_locked);
    end else begin
      n_cmp++;
      if (got_q[0] !== {2'b10, ^d2, d2}) begin
        n_fail++;
        $display("FAIL relock_data: got %h required %h", got_q[0], {2'b10, ^d2, d2});
      end
    end
  endtask

  task automatic test_bad_sequence();
    int v0;
    do_reset();
    o_ready = 1'b1;
    idle(2);
    v0 = viol_cnt;
    send_pre(2'b00);
    send_data(rnd28());
    send_pre(2'b00);
    idle(3);
    n_cmp++;
    if (viol_cnt - v0 != 1 || is_locked !== 1'b0 || got_q.size() != 1) begin
      n_fail++;
      $display("FAIL b_after_b: violations %0d lock %b transfers %0d required 1 0 1",
               viol_cnt - v0, is_locked, got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  types[6] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10};
    logic [30:0] exp_q[$];
    logic [27:0] d;
    int v0, o0;
    do_reset();
    idle(2);
    rand_ready = 1'b1;
    v0 = viol_cnt;
    o0 = ovr_cnt;
    for (int i = 0; i < 6; i++) begin
      d = rnd28();
      exp_q.push_back({types[i], ^d, d});
      send_pre(types[i]);
      send_data(d);
    end
    idle(3);
    n_cmp++;
    if (viol_cnt - v0 != 0 || ovr_cnt - o0 != 0) begin
      n_fail++;
      $display("FAIL seq_errors: violations %0d overruns %0d required 0 0", viol_cnt - v0, ovr_cnt - o0);
    end
    rand_ready = 1'b0;
    o_ready = 1'b1;
    idle(2);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL seq_count: transfers %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL seq_item%0d: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_overrun();
    logic [27:0] d1, d2;
    int o0;
    do_reset();
    d1 = rnd28();
    d2 = rnd28();
    idle(2);
    o0 = ovr_cnt;
    send_pre(2'b00);
    send_data(d1);
    send_pre(2'b10);
    send_data(d2);
    idle(2);
    n_cmp++;
    if ({o_valid, o_preamble, o_subframe} !== {1'b1, 2'b10, d2}) begin
      n_fail++;
      $display("FAIL overrun_held: got v=%b pre=%b sf=%h required 1 10 %h", o_valid, o_preamble, o_subframe, d2);
    end
    o_ready = 1'b1;
    half(1'b0);
    o_ready = 1'b0;
    n_cmp++;
    if (ovr_cnt - o0 != 1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_pulse: overruns %0d o_valid %b required 1 0", ovr_cnt - o0, o_valid);
    end
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== {2'b10, ^d2, d2}) begin
      n_fail++;
      $display("FAIL overrun_transfer: transfers %0d first %h required 1 %h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 31'h0, {2'b10, ^d2, d2});
    end
  endtask

  task automatic test_reset_mid();
    logic [27:0] d, d2;
    do_reset();
    o_ready = 1'b1;
    d = rnd28();
    d2 = rnd28();
    idle(2);
    send_pre(2'b00);
    send_nibs(d, 0, 6);
    reset = 1'b1;
    @(posedge clk128); #1;
    n_cmp++;
    if ({o_valid, o_subframe, o_preamble, parity_error, is_locked, code_violation, is_overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got v=%b sf=%h lock=%b required all 0", o_valid, o_subframe, is_locked);
    end
    reset = 1'b0;
    send_nibs(d, 7, 13);
    idle(4);
    n_cmp++;
    if (got_q.size() != 0 || is_locked !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_discard: transfers %0d lock %b required 0 0", got_q.size(), is_locked);
    end
    send_pre(2'b01);
    send_data(d2);
    idle(4);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== {2'b01, ^d2, d2}) begin
      n_fail++;
      $display("FAIL reset_mid_relock: transfers %0d first %h required 1 %h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 31'h0, {2'b01, ^d2, d2});
    end
  endtask

  initial begin
    test_reset();
    test_latency(1'b0);
    test_latency(1'b1);
    test_parity(28'h0000001);
    test_parity(rnd28());
    test_violation();
    test_bad_sequence();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/spdif_bmc_decoder.md
Name: spdif_bmc_decoder

Overview:
Receive-side counterpart of the S/PDIF BMC encoder. Samples a biphase-mark line clocked by clk128, one half-cell per clock, with the transmitter sharing the clock. It finds preambles and checks BMC coding, then assembles 28-bit subframes (slots 4..31) and presents each one with its preamble type on a valid/ready output. It is used for loopback verification and as the front end of the S/PDIF receive path.

Parameters:
None.

Ports:
clk128  input  1  half-cell clock, 128 x fs; single clock domain
reset  input  1  synchronous, active-high
spdif  input  1  BMC line; one half-cell per clk128
o_valid  output  1  subframe available; held until accepted
o_ready  input  1  downstream accepts when o_valid && o_ready at a rising edge
o_subframe  output  28  bit0 = slot 4 (first in time) ... bit27 = slot 31 (parity)
o_preamble  output  2  00 = B, 01 = M, 10 = W; 11 is never driven
parity_error  output  1  qualifies o_subframe: XOR of o_subframe[27:0] != 0
is_locked  output  1  high while aligned to the subframe structure
code_violation  output  1  one-cycle pulse on a BMC, preamble or sequence error
is_overrun  output  1  one-cycle pulse when a held subframe is overwritten

Behaviour:
- Reset: all outputs are 0, state is HUNT, and all shift registers and counters are cleared. Reset mid-subframe discards partial data. A held o_valid drops.
- Input pipeline:
  - s_q <= spdif every clock.
  - t = s_q ^ s_prev is the transition flag for each half-cell.
  - Decoding uses only t, so an inverted line gives identical results.
- Nibble convention: 4 consecutive t values, first in time is bit3.
  - Data nibble for bits (a, b) is {1, a, 1, b}: 0xA = 00, 0xE = 10, 0xB = 01, 0xF = 11.
  - Preamble nibble pairs: B = 0x9, 0xC; M = 0x9, 0x3; W = 0x9, 0x6.
- State HUNT:
  - An 8-bit shift register of t values is compared against the three preamble patterns every clock.
  - On a match: record the type, set is_locked, clear the nibble counter (0..13) and phase counter (0..3), and go to DATA on the next clock.
- State DATA: on each phase == 3 the completed nibble is checked.
  - If bit3 != 1 or bit1 != 1: pulse code_violation, clear is_locked, go to HUNT, discard the subframe.
  - Otherwise shift bits a and b into the subframe register, filling bit0 upward.
  - After nibble 13: hand the subframe to the output stage and go to PRE.
- State PRE: collect 2 nibbles and check them against the expected type.
  - After B or M, the expected type is W. After W, the expected type is B or M.
  - Match: start DATA.
  - Non-preamble or wrong type: pulse code_violation, drop lock, go to HUNT. The same clock's t history is rechecked by HUNT from the next clock.
- Output stage:
  - Latency: if the final half-cell of slot 31 is on spdif before rising edge N, o_subframe, o_preamble, parity_error and o_valid update at edge N+2.
  - o_valid rises with the new data and stays high until handshake. It drops on the handshake edge unless a new subframe loads on the same edge, in which case it stays high with the new data.
  - A new subframe arriving while o_valid && !o_ready: overwrite the data, keep o_valid high, pulse is_overrun.
  - Subframe data is stable while o_valid && !o_ready, except on overrun.
- Spacing: subframes arrive every 64 clocks, so a consumer that accepts within 64 clocks never overruns.
- Loss of lock never produces o_valid for the partial subframe. A subframe already held in the output stage stays valid.

Test Plan:
1. Reset, then drive B (0x9, 0xC) and 14 x 0xA as transitions -> at +2 clocks: o_valid = 1, o_preamble = 00, o_subframe = 0, parity_error = 0, is_locked = 1. Repeat with an inverted line -> identical outputs.
2. Drive M (0x9, 0x3), then 0xE, then 13 x 0xA, with o_ready = 1 -> o_subframe = 28'h0000001, parity_error = 1, o_valid high for exactly 1 cycle.
3. After lock, drive 0x8 in place of a data nibble -> code_violation pulses 1 cycle, is_locked = 0, no o_valid. Then a valid W plus data -> relocks and delivers that subframe.
4. B subframe followed directly by another B -> code_violation, is_locked = 0. Sequence B, W, M, W -> 4 subframes with o_preamble = 00, 10, 01, 10 and no violation.
5. Two subframes with o_ready = 0 -> is_overrun pulses once and the second subframe is held. Raise o_ready -> single transfer, then o_valid = 0.
6. Assert reset for 1 clock in mid-DATA (nibble 7) -> all outputs 0 the next cycle and no o_valid until the next preamble plus a full subframe.
